// File: rtl/pll_mode_sequencer.sv
// rtl/pll_mode_sequencer.sv - rPLL dynamic reconfiguration sequencer: mode table, reset pulse, lock wait with timeout/retry
// Optional feature macro AUTO_RELOCK_EN: lock loss in LOCKED restarts the sequence at mode_cur.
module pll_mode_sequencer #(
  parameter int NUM_MODES     = 3,
  parameter int INIT_MODE     = 1,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic [1:0] mode_req,
  input  logic       mode_req_valid,
  output logic       mode_req_ready,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic [1:0] mode_cur,
  output logic       locked,
  output logic       busy,
  output logic       fail
);

  localparam int CNT_MAX = (RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int RTY_W   = $clog2(MAX_RETRIES + 2);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [2:0]       MODES_N  = 3'(NUM_MODES);
  localparam logic [1:0]       INIT_M   = 2'(INIT_MODE);

  localparam logic [5:0] OD_DIV2 = 6'h3F;
  localparam logic [5:0] OD_DIV4 = 6'h3E;

  typedef enum logic [2:0] {
    S_APPLY,
    S_WAIT_LOCK,
    S_STABLE,
    S_LOCKED,
    S_FAIL
  } state_t;

  // The rPLL select pins take the inverted divider settings: {IDSEL, FBDSEL, ODSEL}
  function automatic logic [17:0] sel_of(input logic [1:0] m);
    logic [17:0] s;
    s = {~6'd3, ~6'd54, OD_DIV2};
    case (m)
      2'd0:    s = {~6'd0, ~6'd4,  OD_DIV4};
      2'd1:    s = {~6'd3, ~6'd54, OD_DIV2};
      2'd2:    s = {~6'd2, ~6'd13, OD_DIV4};
      default: s = {~6'd3, ~6'd54, OD_DIV2};
    endcase
    return s;
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic [RTY_W-1:0] retry, retry_n;
  logic [1:0]       mode_n;
  logic [17:0]      sel_n;
  logic             locked_n;
  logic             lock_s1, lock_s2;
  logic             accept;
  logic             req_ok;

  assign mode_req_ready = (state == S_LOCKED) || (state == S_FAIL);
  assign pll_reset      = (state == S_APPLY);
  assign busy           = (state == S_APPLY) || (state == S_WAIT_LOCK) || (state == S_STABLE);
  assign fail           = (state == S_FAIL);
  assign accept         = mode_req_valid && mode_req_ready;
  assign req_ok         = ({1'b0, mode_req} < MODES_N);

  always_ff @(posedge clkin) begin
    if (reset) begin
      state                 <= S_APPLY;
      cnt                   <= '0;
      tmo_cnt               <= '0;
      retry                 <= '0;
      mode_cur              <= INIT_M;
      {idsel, fbdsel, odsel} <= sel_of(INIT_M);
      locked                <= 1'b0;
      lock_s1               <= 1'b0;
      lock_s2               <= 1'b0;
    end else begin
      state                 <= state_n;
      cnt                   <= cnt_n;
      tmo_cnt               <= tmo_n;
      retry                 <= retry_n;
      mode_cur              <= mode_n;
      {idsel, fbdsel, odsel} <= sel_n;
      locked                <= locked_n;
      lock_s1               <= pll_lock;
      lock_s2               <= lock_s1;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    tmo_n    = tmo_cnt;
    retry_n  = retry;
    mode_n   = mode_cur;
    sel_n    = {idsel, fbdsel, odsel};
    locked_n = 1'b0;

    case (state)
      S_APPLY: begin
        if (cnt == RST_LAST) begin
          state_n = S_WAIT_LOCK;
          tmo_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      // The timeout counter only advances here; a bounce back from STABLE resumes it
      S_WAIT_LOCK: begin
        if (lock_s2) begin
          state_n = S_STABLE;
          cnt_n   = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          if (retry < RTY_MAX) begin
            retry_n = retry + 1'b1;
            state_n = S_APPLY;
            cnt_n   = '0;
          end else begin
            state_n = S_FAIL;
          end
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s2) begin
          state_n = S_WAIT_LOCK;
        end else if (cnt == STB_LAST) begin
          state_n  = S_LOCKED;
          retry_n  = '0;
          locked_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_LOCKED: begin
`ifdef AUTO_RELOCK_EN
        if (!lock_s2) begin
          state_n = S_APPLY;
          cnt_n   = '0;
          retry_n = '0;
        end else begin
          locked_n = 1'b1;
        end
`else
        locked_n = lock_s2;
`endif
      end
      S_FAIL: begin
        state_n = S_FAIL;
      end
      default: begin
        state_n = S_APPLY;
        cnt_n   = '0;
      end
    endcase

    // A valid request overrides everything; an out-of-range index is simply dropped
    if (accept && req_ok) begin
      state_n  = S_APPLY;
      cnt_n    = '0;
      retry_n  = '0;
      mode_n   = mode_req;
      sel_n    = sel_of(mode_req);
      locked_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// tb/tb_pll_mode_sequencer.sv - table-driven and randomized bench for pll_mode_sequencer
module tb_pll_mode_sequencer;

  localparam int NM = 3;
  localparam int RC = 4;
  localparam int LT = 50;
  localparam int SC = 8;
  localparam int MR = 2;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode_req = 2'd0;
  logic       mode_req_valid = 1'b0;
  logic       mode_req_ready;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [5:0] idsel, fbdsel, odsel;
  logic [1:0] mode_cur;
  logic       locked, busy, fail;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lock_delay = -1;
  int kill_from = 0;
  int kill_to = 0;
  int since = 0;

  int IDIV[3]  = '{0, 3, 2};
  int FBDIV[3] = '{4, 54, 13};
  int ODIV[3]  = '{4, 2, 4};

  typedef struct {
    int          mode;
    int          d;
    int          glitch;
    logic [17:0] esel;
    int          pulses;
    int          lat;
    logic        efail;
    logic [1:0]  ecur;
  } req_t;

  req_t tbl[8];

  pll_mode_sequencer #(
    .NUM_MODES(NM), .INIT_MODE(1), .RESET_CYCLES(RC),
    .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .clkin(clkin), .reset(reset), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .mode_req_ready(mode_req_ready), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel), .mode_cur(mode_cur),
    .locked(locked), .busy(busy), .fail(fail)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  // PLL model: lock rises d cycles after RESET falls, is lost while RESET is high,
  // and can be forced low for a window of cycles
  always @(posedge clkin) begin
    #1;
    if (pll_reset !== 1'b0) since = 0;
    else since = since + 1;
    pll_lock = (pll_reset === 1'b0) && (lock_delay >= 0) && (since > lock_delay)
               && !(cyc >= kill_from && cyc < kill_to);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] model_sel(input int m);
    logic [5:0] od;
    od = 6'h3F << ($clog2(ODIV[m]) - 1);
    return {~6'(IDIV[m]), ~6'(FBDIV[m]), od};
  endfunction

  // Lock is seen by the FSM 3 edges after it appears (capture + two sync stages),
  // then must hold for SC cycles; a dead PLL costs MR+1 full reset+timeout attempts
  function automatic int model_lat(input int d);
    return (d < 0) ? (MR + 1) * (RC + LT) : RC + d + 3 + SC;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_pll_reset"}, 32'(pll_reset), 1);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_fail"}, 32'(fail), 0);
    chk({tag, "_ready"}, 32'(mode_req_ready), 0);
    chk({tag, "_mode_cur"}, 32'(mode_cur), 1);
    chk({tag, "_sel"}, 32'({idsel, fbdsel, odsel}), 32'({6'h3C, 6'h09, 6'h3F}));
  endtask

  // Called at the negedge following the edge 'a' on which the sequence started
  task automatic watch(input int a, input logic [17:0] esel, input int ep, input int elat,
                       input logic efail, input logic [1:0] ecur, input string tag);
    int   pulses = 0;
    int   hi = 0;
    int   n = 0;
    logic prev = 1'b0;
    logic sel_ok = 1'b1;
    logic done = 1'b0;
    chk({tag, "_ready_low"}, 32'(mode_req_ready), 0);
    chk({tag, "_busy_high"}, 32'(busy), 1);
    while (!done && n < 600) begin
      if (pll_reset && !prev) pulses++;
      if (pll_reset) hi++;
      if (!pll_reset && prev) begin
        chk({tag, "_reset_width"}, hi, RC);
        hi = 0;
      end
      if ({idsel, fbdsel, odsel} != esel) sel_ok = 1'b0;
      prev = pll_reset;
      if (locked || fail) done = 1'b1;
      else begin
        @(negedge clkin);
        n++;
      end
    end
    chk({tag, "_finished"}, 32'(done), 1);
    chk({tag, "_latency"}, cyc - a, elat);
    chk({tag, "_pulses"}, pulses, ep);
    chk({tag, "_selects"}, 32'(sel_ok), 1);
    chk({tag, "_mode_cur"}, 32'(mode_cur), 32'(ecur));
    chk({tag, "_fail"}, 32'(fail), 32'(efail));
    chk({tag, "_locked"}, 32'(locked), 32'(!efail));
    chk({tag, "_busy_low"}, 32'(busy), 0);
    chk({tag, "_ready_high"}, 32'(mode_req_ready), 1);
  endtask

  task automatic run_request(input req_t r, input string tag);
    int a;
    int n = 0;
    int highs = 0;
    while (!mode_req_ready && n < 1000) begin
      @(negedge clkin);
      n++;
    end
    chk({tag, "_ready_wait"}, 32'(mode_req_ready), 1);
    if (r.mode < NM) lock_delay = r.d;
    a = cyc + 1;
    if (r.glitch >= 0) begin
      kill_from = a + r.glitch;
      kill_to   = kill_from + 1;
    end
    mode_req       = 2'(r.mode);
    mode_req_valid = 1'b1;
    @(posedge clkin);
    @(negedge clkin);
    mode_req_valid = 1'b0;
    if (r.mode < NM) begin
      watch(a, r.esel, r.pulses, r.lat, r.efail, r.ecur, tag);
    end else begin
      repeat (20) begin
        if (pll_reset) highs++;
        @(negedge clkin);
      end
      chk({tag, "_rej_pulses"}, highs, 0);
      chk({tag, "_rej_mode_cur"}, 32'(mode_cur), 32'(r.ecur));
      chk({tag, "_rej_fail"}, 32'(fail), 32'(r.efail));
      chk({tag, "_rej_locked"}, 32'(locked), 32'(!r.efail));
      chk({tag, "_rej_ready"}, 32'(mode_req_ready), 1);
      chk({tag, "_rej_sel"}, 32'({idsel, fbdsel, odsel}), 32'(r.esel));
    end
  endtask

  initial begin
    int   m_cur;
    logic m_fail;

    tbl[0] = '{2, 10, -1, {6'h3D, 6'h32, 6'h3E}, 1, 25, 1'b0, 2'd2};
    tbl[1] = '{0, 5, -1, {6'h3F, 6'h3B, 6'h3E}, 1, 20, 1'b0, 2'd0};
    tbl[2] = '{3, 5, -1, {6'h3F, 6'h3B, 6'h3E}, 0, 0, 1'b0, 2'd0};
    tbl[3] = '{1, -1, -1, {6'h3C, 6'h09, 6'h3F}, 3, 162, 1'b1, 2'd1};
    tbl[4] = '{3, 5, -1, {6'h3C, 6'h09, 6'h3F}, 0, 0, 1'b1, 2'd1};
    tbl[5] = '{0, 20, -1, {6'h3F, 6'h3B, 6'h3E}, 1, 35, 1'b0, 2'd0};
    tbl[6] = '{0, 3, -1, {6'h3F, 6'h3B, 6'h3E}, 1, 18, 1'b0, 2'd0};
    tbl[7] = '{2, 10, 18, {6'h3D, 6'h32, 6'h3E}, 1, 30, 1'b0, 2'd2};

    reset = 1'b1;
    repeat (3) @(posedge clkin);
    @(negedge clkin);
    check_reset_values("por");
    lock_delay = 10;
    reset = 1'b0;
    watch(cyc, {6'h3C, 6'h09, 6'h3F}, 1, 25, 1'b0, 2'd1, "init");

    for (int i = 0; i < 8; i++) run_request(tbl[i], $sformatf("tbl%0d", i));

    begin : lock_drop
      int g;
      int bad;
      int highs;
      bad   = 0;
      highs = 0;
      g = cyc + 1;
      kill_from = g;
      kill_to   = g + 6;
`ifdef AUTO_RELOCK_EN
      while (cyc < g + 2) begin
        if (!locked || pll_reset) bad++;
        @(negedge clkin);
      end
      chk("drop_hold", bad, 0);
      @(negedge clkin);
      watch(g + 3, {6'h3D, 6'h32, 6'h3E}, 1, 25, 1'b0, 2'd2, "auto_relock");
`else
      repeat (16) begin
        @(negedge clkin);
        if (locked !== !(cyc >= g + 3 && cyc < g + 9)) bad++;
        if (pll_reset) highs++;
      end
      chk("drop_locked_profile", bad, 0);
      chk("drop_no_reset", highs, 0);
      chk("drop_busy", 32'(busy), 0);
      chk("drop_locked_back", 32'(locked), 1);
      chk("drop_mode_cur", 32'(mode_cur), 2);
`endif
    end

    lock_delay = -1;
    mode_req = 2'd2;
    mode_req_valid = 1'b1;
    @(posedge clkin);
    @(negedge clkin);
    mode_req = 2'd0;
    repeat (10) @(negedge clkin);
    chk("mid_in_wait_busy", 32'(busy), 1);
    chk("mid_in_wait_reset_low", 32'(pll_reset), 0);
    reset = 1'b1;
    @(posedge clkin);
    @(negedge clkin);
    check_reset_values("mid");
    mode_req_valid = 1'b0;
    lock_delay = 10;
    reset = 1'b0;
    watch(cyc, {6'h3C, 6'h09, 6'h3F}, 1, 25, 1'b0, 2'd1, "after_reset");

    m_cur  = 1;
    m_fail = 1'b0;
    for (int i = 0; i < 12; i++) begin
      req_t r;
      int   m;
      int   d;
      m = int'($urandom_range(0, 3));
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 40));
      r.mode   = m;
      r.d      = d;
      r.glitch = -1;
      if (m < NM) begin
        r.esel   = model_sel(m);
        r.pulses = (d < 0) ? MR + 1 : 1;
        r.lat    = model_lat(d);
        r.efail  = (d < 0);
        r.ecur   = 2'(m);
        m_cur    = m;
        m_fail   = (d < 0);
      end else begin
        r.esel   = model_sel(m_cur);
        r.pulses = 0;
        r.lat    = 0;
        r.efail  = m_fail;
        r.ecur   = 2'(m_cur);
      end
      run_request(r, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
